sw_job_sequencer: RTL and testbench

//  Sequences one Smith-Waterman alignment job on the Top systolic core: loads the t (query) words,

---
 rtl/sw_job_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_sw_job_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_job_sequencer.sv
// Sequences one Smith-Waterman job on Top: t load, start pulse, on-demand s chunk serving, score capture.
// Optional JOB_TIMEOUT_EN adds a CAL cycle limit (TIMEOUT_CYC) that aborts with o_timeout.
module sw_job_sequencer #(
  parameter int unsigned T_ADDR_W  = 10,
  parameter int unsigned T_W       = 18,
  parameter int unsigned S_ADDR_W  = 8,
  parameter int unsigned S_W       = 128,
  parameter int unsigned S_LEN_W   = 15,
  parameter int unsigned CHUNK_LOG = 6,
  parameter int unsigned SCORE_W   = 16
`ifdef JOB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_job_start,
  input  logic [T_ADDR_W:0]    i_t_len,
  input  logic [S_LEN_W-1:0]   i_s_len,
  output logic                 o_job_busy,
  output logic                 o_job_done,
  output logic [SCORE_W-1:0]   o_score,
  output logic                 o_timeout,
  output logic [T_ADDR_W-1:0]  o_t_addr,
  input  logic [T_W-1:0]       i_t_rdata,
  output logic [S_ADDR_W-1:0]  o_s_addr,
  input  logic [S_W-1:0]       i_s_rdata,
  output logic                 o_set_t,
  output logic                 o_start_cal,
  input  logic                 i_top_busy,
  output logic [T_W-1:0]       o_t,
  input  logic                 i_request_s,
  output logic [S_W-1:0]       o_s,
  output logic [CHUNK_LOG:0]   o_s_valid,
  input  logic [SCORE_W-1:0]   i_result,
  input  logic                 i_result_valid
);

  localparam int unsigned TL_W = T_ADDR_W + 1;
  localparam int unsigned SV_W = CHUNK_LOG + 1;
  localparam logic [S_LEN_W-1:0] CHUNK_CHARS = S_LEN_W'(1 << CHUNK_LOG);

  typedef enum logic [2:0] {IDLE, SET_T, LOAD_T, WAIT_T, START, CAL, DONE} state_t;

  state_t               state;
  logic [TL_W-1:0]      t_len_q;
  logic [TL_W-1:0]      t_cnt;
  logic                 t_vld;
  logic [S_LEN_W-1:0]   s_len_q;
  logic [S_LEN_W-1:0]   s_rem;
  logic [S_ADDR_W-1:0]  s_ptr;
  logic                 rd_pend;
  logic [SV_W-1:0]      rd_valid;
  logic                 s_vld;

  // Memory read data is forwarded in the cycle it returns, gated by a registered qualifier
  assign o_t = t_vld ? i_t_rdata : '0;
  assign o_s = s_vld ? i_s_rdata : '0;

`ifdef JOB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      t_len_q     <= '0;
      t_cnt       <= '0;
      t_vld       <= 1'b0;
      s_len_q     <= '0;
      s_rem       <= '0;
      s_ptr       <= '0;
      rd_pend     <= 1'b0;
      rd_valid    <= '0;
      s_vld       <= 1'b0;
      o_job_busy  <= 1'b0;
      o_job_done  <= 1'b0;
      o_score     <= '0;
      o_t_addr    <= '0;
      o_s_addr    <= '0;
      o_set_t     <= 1'b0;
      o_start_cal <= 1'b0;
      o_s_valid   <= '0;
`ifdef JOB_TIMEOUT_EN
      to_cnt      <= '0;
      o_timeout   <= 1'b0;
`endif
    end else begin
      o_set_t     <= 1'b0;
      o_start_cal <= 1'b0;
      o_job_done  <= 1'b0;
`ifdef JOB_TIMEOUT_EN
      o_timeout   <= 1'b0;
`endif
      // Chunk pipeline: address cycle -> data cycle
      rd_pend   <= 1'b0;
      s_vld     <= rd_pend;
      o_s_valid <= rd_pend ? rd_valid : '0;

      case (state)
        IDLE: begin
          if (i_job_start) begin
            o_job_busy <= 1'b1;
            o_score    <= '0;
            if (i_t_len == '0 || i_s_len == '0) begin
              o_job_done <= 1'b1;
              state      <= DONE;
            end else begin
              t_len_q  <= i_t_len;
              s_len_q  <= i_s_len;
              o_set_t  <= 1'b1;
              o_t_addr <= '0;
              state    <= SET_T;
            end
          end
        end
        SET_T: begin
          t_vld    <= 1'b1;
          t_cnt    <= '0;
          o_t_addr <= o_t_addr + T_ADDR_W'(1);
          state    <= LOAD_T;
        end
        LOAD_T: begin
          t_cnt <= t_cnt + TL_W'(1);
          if (t_cnt + TL_W'(1) == t_len_q) begin
            t_vld    <= 1'b0;
            o_t_addr <= '0;
            state    <= WAIT_T;
          end else begin
            o_t_addr <= o_t_addr + T_ADDR_W'(1);
          end
        end
        WAIT_T: begin
          if (!i_top_busy) begin
            o_start_cal <= 1'b1;
            s_ptr       <= '0;
            s_rem       <= s_len_q;
`ifdef JOB_TIMEOUT_EN
            to_cnt      <= '0;
`endif
            state       <= START;
          end
        end
        START: state <= CAL;
        CAL: begin
          if (i_result_valid) begin
            o_score    <= i_result;
            o_job_done <= 1'b1;
            s_vld      <= 1'b0;
            o_s_valid  <= '0;
            state      <= DONE;
          end
`ifdef JOB_TIMEOUT_EN
          else if (to_hit) begin
            o_score    <= '0;
            o_timeout  <= 1'b1;
            o_job_done <= 1'b1;
            s_vld      <= 1'b0;
            o_s_valid  <= '0;
            state      <= DONE;
          end
`endif
          else begin
`ifdef JOB_TIMEOUT_EN
            to_cnt <= to_cnt + TO_W'(1);
`endif
            // Last chunk of a pass wraps so s re-streams for the next pass
            if (i_request_s && !rd_pend && !s_vld) begin
              o_s_addr <= s_ptr;
              rd_pend  <= 1'b1;
              if (s_rem <= CHUNK_CHARS) begin
                rd_valid <= SV_W'(s_rem);
                s_ptr    <= '0;
                s_rem    <= s_len_q;
              end else begin
                rd_valid <= '1;
                s_ptr    <= s_ptr + S_ADDR_W'(1);
                s_rem    <= s_rem - CHUNK_CHARS;
              end
            end
          end
        end
        DONE: begin
          o_job_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_job_sequencer.sv
// Self-checking bench for sw_job_sequencer: directed job scenarios plus randomized jobs checked
// against a chunk/word reference model. Timeout scenario is built only with JOB_TIMEOUT_EN.
module tb_sw_job_sequencer;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_job_start;
  logic [10:0]   i_t_len;
  logic [14:0]   i_s_len;
  logic          o_job_busy, o_job_done, o_timeout;
  logic [15:0]   o_score;
  logic [9:0]    o_t_addr;
  logic [17:0]   i_t_rdata;
  logic [7:0]    o_s_addr;
  logic [127:0]  i_s_rdata;
  logic          o_set_t, o_start_cal, i_top_busy, i_request_s;
  logic [17:0]   o_t;
  logic [127:0]  o_s;
  logic [6:0]    o_s_valid;
  logic [15:0]   i_result;
  logic          i_result_valid;

  logic [17:0]   t_mem [1024];
  logic [127:0]  s_mem [256];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Synchronous read memories: address in one cycle, data the next
  always @(posedge clk) begin
    i_t_rdata <= t_mem[o_t_addr];
    i_s_rdata <= s_mem[o_s_addr];
  end

`ifdef JOB_TIMEOUT_EN
  sw_job_sequencer #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .i_job_start(i_job_start), .i_t_len(i_t_len), .i_s_len(i_s_len),
    .o_job_busy(o_job_busy), .o_job_done(o_job_done), .o_score(o_score), .o_timeout(o_timeout),
    .o_t_addr(o_t_addr), .i_t_rdata(i_t_rdata), .o_s_addr(o_s_addr), .i_s_rdata(i_s_rdata),
    .o_set_t(o_set_t), .o_start_cal(o_start_cal), .i_top_busy(i_top_busy), .o_t(o_t),
    .i_request_s(i_request_s), .o_s(o_s), .o_s_valid(o_s_valid), .i_result(i_result),
    .i_result_valid(i_result_valid)
  );
`else
  sw_job_sequencer dut (
    .clk(clk), .rst(rst), .i_job_start(i_job_start), .i_t_len(i_t_len), .i_s_len(i_s_len),
    .o_job_busy(o_job_busy), .o_job_done(o_job_done), .o_score(o_score), .o_timeout(o_timeout),
    .o_t_addr(o_t_addr), .i_t_rdata(i_t_rdata), .o_s_addr(o_s_addr), .i_s_rdata(i_s_rdata),
    .o_set_t(o_set_t), .o_start_cal(o_start_cal), .i_top_busy(i_top_busy), .o_t(o_t),
    .i_request_s(i_request_s), .o_s(o_s), .o_s_valid(o_s_valid), .i_result(i_result),
    .i_result_valid(i_result_valid)
  );
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a pass over s is ceil(s_len/64) chunks; only the last is partial
  function automatic int num_chunks(input int s_len);
    return (s_len + 63) / 64;
  endfunction

  function automatic int exp_valid(input int s_len, input int addr);
    int n = num_chunks(s_len);
    return (addr == n - 1) ? (s_len - 64 * (n - 1)) : 127;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, o_job_busy, 0);
    chk({tag, "_done"}, o_job_done, 0);
    chk({tag, "_score"}, o_score, 0);
    chk({tag, "_set_t"}, o_set_t, 0);
    chk({tag, "_start_cal"}, o_start_cal, 0);
    chk({tag, "_t"}, o_t, 0);
    chk({tag, "_t_addr"}, o_t_addr, 0);
    chk({tag, "_s_valid"}, o_s_valid, 0);
    chk({tag, "_timeout"}, o_timeout, 0);
  endtask

  // Start a job and drive it up to the first CAL cycle
  task automatic job_begin(input int tl, input int sl, input int busy_wait);
    i_top_busy  = 1'b1;
    i_t_len     = 11'(tl);
    i_s_len     = 15'(sl);
    i_job_start = 1'b1;
    @(negedge clk);
    i_job_start = 1'b0;
    chk("set_t_pulse", o_set_t, 1);
    chk("t_addr_first", o_t_addr, 0);
    chk("busy_on", o_job_busy, 1);
    chk("t_before_load", o_t, 0);
    for (int i = 0; i < tl; i++) begin
      @(negedge clk);
      chk("t_word", o_t, t_mem[i]);
      chk("set_t_single", o_set_t, 0);
    end
    @(negedge clk);
    chk("t_after_load", o_t, 0);
    for (int i = 0; i < busy_wait; i++) begin
      i_result_valid = 1'($urandom_range(0, 1));
      i_result       = 16'hFFFF;
      @(negedge clk);
      chk("no_start_while_busy", o_start_cal, 0);
      chk("result_outside_cal", o_job_done, 0);
    end
    i_result_valid = 1'b0;
    i_top_busy     = 1'b0;
    @(negedge clk);
    chk("start_cal_pulse", o_start_cal, 1);
    i_top_busy = 1'b1;
    @(negedge clk);
    chk("start_cal_single", o_start_cal, 0);
  endtask

  // Request chunk number idx of the stream; hold > 1 keeps the request up while in flight
  task automatic req_chunk(input int sl, input int idx, input int hold);
    int a = idx % num_chunks(sl);
    i_request_s = 1'b1;
    @(negedge clk);
    if (hold < 2) i_request_s = 1'b0;
    chk("s_addr", o_s_addr, a);
    chk("s_valid_addr_cycle", o_s_valid, 0);
    @(negedge clk);
    if (hold < 3) i_request_s = 1'b0;
    chk("s_data", o_s, s_mem[a]);
    chk("s_valid", o_s_valid, exp_valid(sl, a));
    @(negedge clk);
    i_request_s = 1'b0;
    chk("s_valid_clear", o_s_valid, 0);
    chk("s_data_clear", o_s, 0);
  endtask

  task automatic job_end(input logic [15:0] res);
    i_result       = res;
    i_result_valid = 1'b1;
    @(negedge clk);
    i_result_valid = 1'b0;
    chk("done_pulse", o_job_done, 1);
    chk("score", o_score, res);
    chk("timeout_low", o_timeout, 0);
    chk("busy_in_done", o_job_busy, 1);
    @(negedge clk);
    chk("done_single", o_job_done, 0);
    chk("busy_off", o_job_busy, 0);
    chk("score_held", o_score, res);
  endtask

  initial begin
    rst = 1'b1; i_job_start = 1'b0; i_t_len = '0; i_s_len = '0; i_top_busy = 1'b0;
    i_request_s = 1'b0; i_result = '0; i_result_valid = 1'b0;
    for (int i = 0; i < 1024; i++) t_mem[i] = 18'($urandom);
    for (int i = 0; i < 256; i++) s_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic job: 3 t words, 10 chars -> one partial chunk
    job_begin(3, 10, 2);
    req_chunk(10, 0, 1);
    job_end(16'h1234);

    // 130 chars: 7F,7F,2 then wrap; first request held through its flight, start pulsed in CAL
    job_begin(5, 130, 0);
    req_chunk(130, 0, 3);
    i_job_start = 1'b1;
    i_t_len = 11'd4; i_s_len = 15'd4;
    @(negedge clk);
    i_job_start = 1'b0;
    chk("start_in_cal_ignored", o_set_t, 0);
    chk("busy_kept", o_job_busy, 1);
    @(negedge clk);
    chk("start_in_cal_set_t", o_set_t, 0);
    req_chunk(130, 1, 1);
    req_chunk(130, 2, 1);
    req_chunk(130, 3, 1);
    job_end(16'h0BEE);

    // Exactly 64 chars: full single chunk reports 64, not all-ones
    job_begin(1, 64, 1);
    req_chunk(64, 0, 1);
    req_chunk(64, 1, 1);
    job_end(16'h0040);

    // Zero lengths complete immediately with no Top activity
    for (int k = 0; k < 2; k++) begin
      i_t_len = (k == 0) ? 11'd0 : 11'd4;
      i_s_len = (k == 0) ? 15'd5 : 15'd0;
      i_job_start = 1'b1;
      @(negedge clk);
      i_job_start = 1'b0;
      chk("zero_done", o_job_done, 1);
      chk("zero_score", o_score, 0);
      chk("zero_set_t", o_set_t, 0);
      @(negedge clk);
      chk("zero_done_single", o_job_done, 0);
      chk("zero_set_t_after", o_set_t, 0);
      chk("zero_start_cal", o_start_cal, 0);
      chk("zero_busy_off", o_job_busy, 0);
    end

    // Request and result in the same cycle: result wins, no chunk served
    job_begin(2, 200, 0);
    i_request_s = 1'b1; i_result = 16'h5A5A; i_result_valid = 1'b1;
    @(negedge clk);
    i_request_s = 1'b0; i_result_valid = 1'b0;
    chk("tie_done", o_job_done, 1);
    chk("tie_score", o_score, 16'h5A5A);
    chk("tie_s_valid", o_s_valid, 0);
    @(negedge clk);
    chk("tie_s_valid_after", o_s_valid, 0);
    chk("tie_s_after", o_s, 0);
    chk("tie_busy_off", o_job_busy, 0);

    // Reset in the middle of LOAD_T aborts silently
    i_t_len = 11'd10; i_s_len = 15'd20; i_job_start = 1'b1;
    @(negedge clk);
    i_job_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("midreset");
    repeat (3) begin
      @(negedge clk);
      chk("midreset_no_done", o_job_done, 0);
      chk("midreset_no_t", o_t, 0);
    end

    // Randomized jobs
    for (int j = 0; j < 5; j++) begin
      int tl = $urandom_range(1, 20);
      int sl = $urandom_range(1, 700);
      int nr = $urandom_range(1, 12);
      logic [15:0] res = 16'($urandom);
      job_begin(tl, sl, $urandom_range(0, 4));
      for (int r = 0; r < nr; r++) begin
        req_chunk(sl, r, 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      job_end(res);
    end

`ifdef JOB_TIMEOUT_EN
    // No result: abort exactly 100 cycles into CAL
    job_begin(2, 100, 0);
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      chk("to_not_yet", o_job_done, 0);
    end
    @(negedge clk);
    chk("to_done", o_job_done, 1);
    chk("to_flag", o_timeout, 1);
    chk("to_score", o_score, 0);
    @(negedge clk);
    chk("to_flag_single", o_timeout, 0);
    chk("to_busy_off", o_job_busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
